fdau_rd_arbiter: RTL and testbench
==================================

FDAU_RD_ARBITER -- requirements
Module: fdau_rd_arbiter

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 260, frame word count (addresses 0..259 of 512-word frame RAM).
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from rd_addr stable to ram_q valid.
REQ-003 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high.
REQ-005 SHALL have port frame_done  input  1  one-cycle pulse from frame writer: frame complete.
REQ-006 SHALL have port stream_en  input  1  enables automatic frame streaming.
REQ-007 SHALL have port hreq  input  1  host read request, level, held until hgnt.
REQ-008 SHALL have port haddr  input  9  host read address, stable while hreq=1.
REQ-009 SHALL have port hgnt  output  1  one-cycle grant pulse to host.
REQ-010 SHALL have port hvalid  output  1  one-cycle pulse: hdata valid.
REQ-011 SHALL have port hdata  output  16  host read data, held until next hvalid.
REQ-012 SHALL have port sdata  output  16  stream word.
REQ-013 SHALL have port svalid  output  1  stream word valid, held until accepted.
REQ-014 SHALL have port sready  input  1  stream consumer accepts when svalid&sready.
REQ-015 SHALL have port s_busy  output  1  frame burst in progress.
REQ-016 SHALL have port s_done  output  1  one-cycle pulse after last word accepted.
REQ-017 SHALL have port s_ovr  output  1  sticky overrun flag.
REQ-018 SHALL have port ovr_clr  input  1  clears s_ovr.
REQ-019 SHALL have port rd_addr  output  9  registered RAM read address.
REQ-020 SHALL have port ram_q  input  16  RAM read data.

Function
REQ-021 SHALL keep at most one RAM read in flight; port FSM states IDLE, ISSUE, WAIT, CAPTURE.
REQ-022 Grant in cycle T (IDLE, request pending): rd_addr loads at end of T; WAIT lasts RD_LAT cycles; ram_q captured at end of T+RD_LAT+1; valid pulse/assertion at T+RD_LAT+2.
REQ-023 Next grant SHALL be possible no earlier than cycle T+RD_LAT+2 (back-to-back period RD_LAT+2).
REQ-024 Requesters: host (hreq=1) and streamer (s_busy=1, stream word register empty, words remaining).
REQ-025 Both pending in same cycle: round-robin; grant goes to requester not granted last; after reset pointer favours host.
REQ-026 Streamer read SHALL NOT issue while svalid=1; read port remains available to host meanwhile.
REQ-027 frame_done=1 with stream_en=1 and s_busy=0: s_busy<=1, stream address <=0, word count <=0, next cycle.
REQ-028 frame_done with stream_en=0: ignored, no flag.
REQ-029 frame_done while s_busy=1: s_ovr<=1, burst continues unaffected, pulse otherwise ignored.
REQ-030 ovr_clr and overrun in same cycle: set wins.
REQ-031 Stream word captured: sdata<=ram_q, svalid<=1; svalid&sready: svalid<=0, address +1.
REQ-032 Acceptance of word FRAME_LEN-1: s_busy<=0, s_done=1 for one cycle, same edge as svalid falls.
REQ-033 stream_en sampled only at burst start; deassertion mid-burst does not abort.
REQ-034 Addresses SHALL be 9 bits, no wrap beyond FRAME_LEN-1 for stream; haddr passed unchanged (0..511).
REQ-035 hgnt SHALL pulse exactly once per accepted host request; hreq held after hvalid counts as new request.
REQ-036 frame_done coincident with final acceptance (s_busy=1 that cycle): counts as overrun.

Reset
REQ-037 Reset SHALL force: FSM IDLE, rd_addr=0, hdata=0, sdata=0, hgnt=0, hvalid=0, svalid=0, s_busy=0, s_done=0, s_ovr=0, rr pointer=host.
REQ-038 Reset mid-burst or mid-read SHALL abort without s_done or hvalid; operation resumes only on new frame_done/hreq.

Verification
REQ-039 Host only, RD_LAT=1, haddr=0x005, RAM[5]=0xA5A5 -> hgnt at T, rd_addr=5 at T+1, hvalid with hdata=0xA5A5 at T+3.
REQ-040 stream_en=1, frame_done, sready=1 constant, RAM[n]=n -> 260 words 0..259 in order, s_done once, s_busy low after.
REQ-041 Host hreq held continuously during stream -> grants alternate host/stream; no word lost, stream order intact.
REQ-042 sready=0 for 50 cycles at word 10 -> svalid, sdata=10 held; host reads still served; resume on sready=1.
REQ-043 Second frame_done at word 100 -> s_ovr=1, burst completes to 259; ovr_clr -> s_ovr=0.
REQ-044 Reset asserted at word 37 -> all outputs reset values, no s_done; new frame_done restarts at address 0.

Source files
------------

// File: rtl/fdau_rd_arbiter.sv
// Shares one frame-RAM read port between host reads and a frame streamer, one read in flight at a time.
// Latency: hgnt in the ISSUE cycle T, rd_addr from T+1, hvalid / svalid at T+RD_LAT+2; next grant no earlier than T+RD_LAT+2.
// Backpressure: the stream word register holds sdata/svalid until sready; host reads keep flowing while it is full.
module fdau_rd_arbiter #(
    parameter int FRAME_LEN = 260,
    parameter int RD_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_done,
    input  logic        stream_en,
    input  logic        hreq,
    input  logic [8:0]  haddr,
    output logic        hgnt,
    output logic        hvalid,
    output logic [15:0] hdata,
    output logic [15:0] sdata,
    output logic        svalid,
    input  logic        sready,
    output logic        s_busy,
    output logic        s_done,
    output logic        s_ovr,
    input  logic        ovr_clr,
    output logic [8:0]  rd_addr,
    input  logic [15:0] ram_q
);

    // Wait counter only needs to reach RD_LAT-1.
    localparam int             WCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WCNT_LAST = WCW'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
    localparam logic [8:0]     LAST_ADDR = 9'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Read-port state
    state_t         state_q;
    logic           owner_strm_q;   // 1: read in flight belongs to the streamer
    logic           prio_host_q;    // round-robin: host wins the next tie
    logic [WCW-1:0] wcnt_q;
    logic           hgnt_q;
    logic           hvalid_q;
    logic [15:0]    hdata_q;
    logic [8:0]     rd_addr_q;

    // Streamer state
    logic           s_busy_q;
    logic           svalid_q;
    logic           s_done_q;
    logic           s_ovr_q;
    logic [15:0]    sdata_q;
    logic [8:0]     s_addr_q;       // next stream word to fetch / word count

    // Arbitration terms
    logic           can_grant;
    logic           host_pend;
    logic           strm_pend;
    logic           gnt_host;
    logic           gnt_strm;
    logic           s_cap;
    logic           s_accept;

    // Request and grant decode; a requester whose read is still in flight is not pending again.
    always_comb begin
        can_grant = (state_q == IDLE) || (state_q == CAPTURE);
        host_pend = hreq && !((state_q != IDLE) && !owner_strm_q);
        strm_pend = s_busy_q && !svalid_q && !((state_q != IDLE) && owner_strm_q);
        gnt_host  = can_grant && host_pend && (!strm_pend || prio_host_q);
        gnt_strm  = can_grant && strm_pend && !gnt_host;
        s_cap     = (state_q == CAPTURE) && owner_strm_q;
        s_accept  = svalid_q && sready;
    end

    // Read-port FSM: grant, drive the RAM address, wait out RD_LAT, capture host data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_strm_q <= 1'b0;
            prio_host_q  <= 1'b1;
            wcnt_q       <= '0;
            hgnt_q       <= 1'b0;
            hvalid_q     <= 1'b0;
            hdata_q      <= '0;
            rd_addr_q    <= '0;
        end else begin
            hgnt_q   <= gnt_host;
            hvalid_q <= (state_q == CAPTURE) && !owner_strm_q;
            if (gnt_host || gnt_strm) begin
                owner_strm_q <= gnt_strm;
                prio_host_q  <= gnt_strm;
            end
            case (state_q)
                IDLE: begin
                    if (gnt_host || gnt_strm) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // haddr is still held by the host in the grant cycle; s_addr cannot
                    // move while the stream register is empty.
                    rd_addr_q <= owner_strm_q ? s_addr_q : haddr;
                    wcnt_q    <= '0;
                    state_q   <= (RD_LAT == 0) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    if (wcnt_q == WCNT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!owner_strm_q) begin
                        hdata_q <= ram_q;
                    end
                    state_q <= (gnt_host || gnt_strm) ? ISSUE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Streamer: burst start on frame_done, word register load/unload, end-of-frame and overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_busy_q <= 1'b0;
            svalid_q <= 1'b0;
            s_done_q <= 1'b0;
            s_ovr_q  <= 1'b0;
            sdata_q  <= '0;
            s_addr_q <= '0;
        end else begin
            s_done_q <= 1'b0;
            if (s_cap) begin
                sdata_q  <= ram_q;
                svalid_q <= 1'b1;
            end else if (s_accept) begin
                svalid_q <= 1'b0;
                if (s_addr_q == LAST_ADDR) begin
                    s_busy_q <= 1'b0;
                    s_done_q <= 1'b1;
                end else begin
                    s_addr_q <= s_addr_q + 9'd1;
                end
            end
            // A frame_done seen while busy (even on the final acceptance) is an overrun
            // and never restarts the burst; stream_en only matters at burst start.
            if (frame_done && !s_busy_q && stream_en) begin
                s_busy_q <= 1'b1;
                s_addr_q <= '0;
            end
            if (frame_done && s_busy_q) begin
                s_ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                s_ovr_q <= 1'b0;
            end
        end
    end

    assign hgnt    = hgnt_q;
    assign hvalid  = hvalid_q;
    assign hdata   = hdata_q;
    assign rd_addr = rd_addr_q;
    assign sdata   = sdata_q;
    assign svalid  = svalid_q;
    assign s_busy  = s_busy_q;
    assign s_done  = s_done_q;
    assign s_ovr   = s_ovr_q;

endmodule

// File: tb/tb_fdau_rd_arbiter.sv
// Directed bench for fdau_rd_arbiter with a 1-cycle synchronous RAM model.
// Latency: checks host read timing, stream order, arbitration, stall, overrun and reset abort.
// Backpressure: sready is driven per cycle by the stall scenario.
module tb_fdau_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_done;
    logic        stream_en;
    logic        hreq;
    logic [8:0]  haddr;
    logic        hgnt;
    logic        hvalid;
    logic [15:0] hdata;
    logic [15:0] sdata;
    logic        svalid;
    logic        sready;
    logic        s_busy;
    logic        s_done;
    logic        s_ovr;
    logic        ovr_clr;
    logic [8:0]  rd_addr;
    logic [15:0] ram_q;

    logic [15:0] mem [0:511];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Synchronous RAM, RD_LAT = 1
    always @(posedge clock) ram_q <= mem[rd_addr];

    fdau_rd_arbiter #(.FRAME_LEN(260), .RD_LAT(1)) dut (
        .clock(clock), .reset(reset), .frame_done(frame_done), .stream_en(stream_en),
        .hreq(hreq), .haddr(haddr), .hgnt(hgnt), .hvalid(hvalid), .hdata(hdata),
        .sdata(sdata), .svalid(svalid), .sready(sready), .s_busy(s_busy),
        .s_done(s_done), .s_ovr(s_ovr), .ovr_clr(ovr_clr), .rd_addr(rd_addr), .ram_q(ram_q)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; frame_done = 1'b0; stream_en = 1'b0; hreq = 1'b0; haddr = '0;
        sready = 1'b0; ovr_clr = 1'b0;
        repeat (3) tick();
        checks++; if ({hgnt, hvalid, svalid, s_busy, s_done, s_ovr} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {hgnt, hvalid, svalid, s_busy, s_done, s_ovr}); end
        checks++; if (rd_addr !== 9'd0) begin errors++; $display("FAIL reset_rd_addr: got %h want 000", rd_addr); end
        checks++; if ({hdata, sdata} !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {hdata, sdata}); end
        reset = 1'b0;
        repeat (2) tick();
        checks++; if ({hgnt, hvalid, svalid, s_busy} !== 4'b0) begin errors++; $display("FAIL reset_idle: got %b want 0000", {hgnt, hvalid, svalid, s_busy}); end
    endtask

    task automatic test_host_read;
        int t;
        mem[5] = 16'hA5A5;
        haddr = 9'h005; hreq = 1'b1;
        t = -1;
        for (int c = 0; c < 20 && t < 0; c++) begin
            tick();
            if (hgnt) t = 0;
        end
        checks++;
        if (t < 0) begin errors++; $display("FAIL host_gnt_timeout: no hgnt in 20 cycles"); hreq = 1'b0; return; end
        tick(); hreq = 1'b0;                 // T+1
        checks++; if (rd_addr !== 9'h005) begin errors++; $display("FAIL host_rd_addr: got %h want 005", rd_addr); end
        checks++; if ({hgnt, hvalid} !== 2'b00) begin errors++; $display("FAIL host_t1: got hgnt,hvalid=%b want 00", {hgnt, hvalid}); end
        tick();                              // T+2
        checks++; if (hvalid !== 1'b0) begin errors++; $display("FAIL host_t2_hvalid: got %b want 0", hvalid); end
        tick();                              // T+3
        checks++; if (hvalid !== 1'b1) begin errors++; $display("FAIL host_t3_hvalid: got %b want 1", hvalid); end
        checks++; if (hdata !== 16'hA5A5) begin errors++; $display("FAIL host_t3_hdata: got %h want a5a5", hdata); end
        tick();                              // T+4
        checks++; if ({hgnt, hvalid} !== 2'b00) begin errors++; $display("FAIL host_t4: got hgnt,hvalid=%b want 00", {hgnt, hvalid}); end
        checks++; if (hdata !== 16'hA5A5) begin errors++; $display("FAIL host_hdata_hold: got %h want a5a5", hdata); end
        mem[5] = 16'h0005;
    endtask

    task automatic test_stream_basic;
        int idx, dones, post;
        // frame_done with stream_en low is ignored
        stream_en = 1'b0; frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
        checks++; if ({s_busy, s_ovr, svalid} !== 3'b000) begin errors++; $display("FAIL ignore_fd: got busy,ovr,svalid=%b want 000", {s_busy, s_ovr, svalid}); end
        stream_en = 1'b1; sready = 1'b1; frame_done = 1'b1; tick(); frame_done = 1'b0;
        stream_en = 1'b0;                    // mid-burst deassert must not abort
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", s_busy); end
        idx = 0; dones = 0; post = 0;
        for (int c = 0; c < 2000 && post < 10; c++) begin
            if (svalid && sready) begin
                checks++; if (sdata !== 16'(idx)) begin errors++; $display("FAIL basic_word: got %h want %h", sdata, 16'(idx)); end
                idx++;
            end
            if (s_done) begin
                dones++;
                checks++; if (idx !== 260) begin errors++; $display("FAIL basic_done_pos: got %0d words want 260", idx); end
            end
            if (dones > 0) post++;
            tick();
        end
        checks++; if (idx !== 260) begin errors++; $display("FAIL basic_count: got %0d want 260", idx); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL basic_sdone: got %0d want 1", dones); end
        checks++; if ({s_busy, svalid} !== 2'b00) begin errors++; $display("FAIL basic_end: got busy,svalid=%b want 00", {s_busy, svalid}); end
    endtask

    task automatic test_stream_with_host;
        int idx, dones, post, ng, nv, w_prev, last_g;
        idx = 0; dones = 0; post = 0; ng = 0; nv = 0; w_prev = 0; last_g = -100;
        haddr = 9'h100; hreq = 1'b1; stream_en = 1'b1; sready = 1'b1; frame_done = 1'b1;
        tick(); frame_done = 1'b0;
        for (int c = 0; c < 4000 && post < 10; c++) begin
            if (hgnt) begin
                checks++; if (c - last_g < 3) begin errors++; $display("FAIL b2b_gap: got %0d cycles want >=3", c - last_g); end
                if (ng > 0 && w_prev >= 1 && w_prev <= 259) begin
                    checks++; if (idx !== w_prev + 1) begin errors++; $display("FAIL alternate: got %0d words want %0d", idx, w_prev + 1); end
                end
                w_prev = idx; last_g = c; ng++;
            end
            if (hvalid) begin
                nv++;
                checks++; if (hdata !== 16'h0100) begin errors++; $display("FAIL mix_hdata: got %h want 0100", hdata); end
            end
            if (svalid && sready) begin
                checks++; if (sdata !== 16'(idx)) begin errors++; $display("FAIL mix_word: got %h want %h", sdata, 16'(idx)); end
                idx++;
            end
            if (s_done) dones++;
            if (dones > 0) post++;
            tick();
        end
        hreq = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (hvalid) nv++;
            tick();
        end
        checks++; if (idx !== 260) begin errors++; $display("FAIL mix_count: got %0d want 260", idx); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL mix_sdone: got %0d want 1", dones); end
        checks++; if (ng < 260) begin errors++; $display("FAIL mix_grants: got %0d want >=260", ng); end
        checks++; if (nv !== ng) begin errors++; $display("FAIL mix_hvalid: got %0d want %0d", nv, ng); end
    endtask

    task automatic test_stall;
        int idx, dones, post, st, served;
        idx = 0; dones = 0; post = 0; st = 0; served = 0;
        hreq = 1'b0; stream_en = 1'b1; sready = 1'b1; frame_done = 1'b1;
        tick(); frame_done = 1'b0;
        for (int c = 0; c < 3000 && post < 10; c++) begin
            if (svalid && idx == 10 && st < 50) begin
                sready = 1'b0; st++;
                checks++; if ({s_busy, sdata} !== {1'b1, 16'd10}) begin errors++; $display("FAIL stall_hold: got busy,sdata=%b,%h want 1,000a", s_busy, sdata); end
                if (st == 5) begin hreq = 1'b1; haddr = 9'h1AB; end
            end else begin
                sready = 1'b1;
            end
            if (hgnt) hreq = 1'b0;
            if (hvalid) begin
                checks++; if (hdata !== 16'h01AB) begin errors++; $display("FAIL stall_hdata: got %h want 01ab", hdata); end
                if (st > 0 && st < 50) served++;
            end
            if (svalid && sready) begin
                checks++; if (sdata !== 16'(idx)) begin errors++; $display("FAIL stall_word: got %h want %h", sdata, 16'(idx)); end
                idx++;
            end
            if (s_done) dones++;
            if (dones > 0) post++;
            tick();
        end
        sready = 1'b1;
        checks++; if (st !== 50) begin errors++; $display("FAIL stall_len: got %0d want 50", st); end
        checks++; if (served !== 1) begin errors++; $display("FAIL stall_host: got %0d reads want 1", served); end
        checks++; if (idx !== 260 || dones !== 1) begin errors++; $display("FAIL stall_end: got %0d words %0d done want 260 1", idx, dones); end
    endtask

    task automatic test_overrun;
        int idx, dones, post;
        logic exp_ovr;
        idx = 0; dones = 0; post = 0; exp_ovr = 1'b0;
        stream_en = 1'b1; sready = 1'b1; frame_done = 1'b1;
        tick(); frame_done = 1'b0;
        for (int c = 0; c < 2000 && post < 10; c++) begin
            checks++; if (s_ovr !== exp_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b at word %0d", s_ovr, exp_ovr, idx); end
            frame_done = 1'b0; ovr_clr = 1'b0;
            if (svalid && sready) begin
                checks++; if (sdata !== 16'(idx)) begin errors++; $display("FAIL ovr_word: got %h want %h", sdata, 16'(idx)); end
                if (idx == 100) frame_done = 1'b1;
                if (idx == 150) ovr_clr = 1'b1;
                if (idx == 259) begin frame_done = 1'b1; ovr_clr = 1'b1; end
                idx++;
            end
            if (frame_done) exp_ovr = 1'b1;
            else if (ovr_clr) exp_ovr = 1'b0;
            if (s_done) dones++;
            if (dones > 0) post++;
            tick();
        end
        frame_done = 1'b0; ovr_clr = 1'b0;
        checks++; if (idx !== 260 || dones !== 1) begin errors++; $display("FAIL ovr_end: got %0d words %0d done want 260 1", idx, dones); end
        checks++; if ({s_busy, s_ovr} !== 2'b01) begin errors++; $display("FAIL ovr_final: got busy,ovr=%b want 01", {s_busy, s_ovr}); end
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        checks++; if (s_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", s_ovr); end
    endtask

    task automatic test_reset_mid_burst;
        int idx, quiet;
        idx = 0; quiet = 0;
        stream_en = 1'b1; sready = 1'b1; frame_done = 1'b1;
        tick(); frame_done = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (svalid && idx == 37) break;
            if (svalid && sready) idx++;
            tick();
        end
        checks++; if (idx !== 37) begin errors++; $display("FAIL rst_reach: got word %0d want 37", idx); end
        reset = 1'b1; #1;
        checks++; if ({hgnt, hvalid, svalid, s_busy, s_done, s_ovr} !== 6'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 000000", {hgnt, hvalid, svalid, s_busy, s_done, s_ovr}); end
        checks++; if ({hdata, sdata, rd_addr} !== 41'd0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", {hdata, sdata, rd_addr}); end
        tick(); reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if ({s_done, svalid, s_busy, hvalid} !== 4'b0) quiet++;
        end
        checks++; if (quiet !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", quiet); end
        // Restart; host request rises the cycle the streamer becomes pending: host wins after reset.
        frame_done = 1'b1; tick(); frame_done = 1'b0;
        hreq = 1'b1; haddr = 9'h003; tick();
        checks++; if (hgnt !== 1'b1) begin errors++; $display("FAIL rr_after_reset: got hgnt=%b want 1", hgnt); end
        hreq = 1'b0;
        idx = 0;
        for (int c = 0; c < 100 && idx < 3; c++) begin
            if (svalid && sready) begin
                checks++; if (sdata !== 16'(idx)) begin errors++; $display("FAIL restart_word: got %h want %h", sdata, 16'(idx)); end
                idx++;
            end
            tick();
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL restart_timeout: got %0d words want 3", idx); end
        reset = 1'b1; tick(); reset = 1'b0; tick();
        // Reset during an in-flight host read produces no hvalid.
        hreq = 1'b1; haddr = 9'h007; idx = 0;
        for (int c = 0; c < 20 && idx == 0; c++) begin
            tick();
            if (hgnt) idx = 1;
        end
        hreq = 1'b0;
        checks++; if (idx !== 1) begin errors++; $display("FAIL midread_gnt: no hgnt"); end
        tick(); reset = 1'b1; tick(); reset = 1'b0;
        quiet = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (hvalid !== 1'b0 || hdata !== 16'd0) quiet++;
        end
        checks++; if (quiet !== 0) begin errors++; $display("FAIL midread_abort: got %0d hvalid/hdata cycles want 0", quiet); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i);
        test_reset();
        test_host_read();
        test_stream_basic();
        test_stream_with_host();
        test_stall();
        test_overrun();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
